pio_loader: RTL and testbench

PIO_LOADER -- requirements
Module: pio_loader

---
 rtl/pio_loader.sv | 328 ++++++++++++++++++++++++++++++++
 tb/tb_pio_loader.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pio_loader.sv
// pio_loader: streams a stored PIO program, then per-machine config and enables, as one action per cycle.
// Optional macro PIO_LOADER_SIDES_EN adds an sm_sides input and a SIDES action after GRPS.
module pio_loader #(
   parameter int NUM_SM     = 4,
   parameter int PROG_DEPTH = 32
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 prog_we,
   input  logic [4:0]           prog_addr,
   input  logic [15:0]          prog_data,
   input  logic [5:0]           plen,
   input  logic [NUM_SM-1:0]    sm_en_mask,
   input  logic [NUM_SM*5-1:0]  sm_pend,
   input  logic [NUM_SM*24-1:0] sm_div,
   input  logic [NUM_SM*32-1:0] sm_grps,
`ifdef PIO_LOADER_SIDES_EN
   input  logic [NUM_SM*32-1:0] sm_sides,
`endif
   input  logic                 start,
   input  logic                 hold,
   output logic [3:0]           action,
   output logic [4:0]           index,
   output logic [1:0]           mindex,
   output logic [31:0]          din,
   output logic                 busy,
   output logic                 done,
   output logic                 err
);

   localparam logic [3:0] ACT_NONE  = 4'd0;
   localparam logic [3:0] ACT_INSTR = 4'd1;
   localparam logic [3:0] ACT_PEND  = 4'd2;
   localparam logic [3:0] ACT_GRPS  = 4'd5;
   localparam logic [3:0] ACT_EN    = 4'd6;
   localparam logic [3:0] ACT_DIV   = 4'd7;
`ifdef PIO_LOADER_SIDES_EN
   localparam logic [3:0] ACT_SIDES = 4'd8;
   localparam logic [1:0] LAST_SUB  = 2'd3;
`else
   localparam logic [1:0] LAST_SUB  = 2'd2;
`endif

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      INSTR = 3'd1,
      CFG   = 3'd2,
      EN    = 3'd3,
      FIN   = 3'd4
   } state_t;

   state_t                state_r, state_nxt_s;
   logic [4:0]            idx_r, idx_nxt_s;
   logic [1:0]            m_r, m_nxt_s;
   logic [1:0]            sub_r, sub_nxt_s;

   logic [15:0]           prog_mem_r [PROG_DEPTH];

   logic [5:0]            plen_r;
   logic [NUM_SM-1:0]     mask_r;
   logic [NUM_SM*5-1:0]   pend_r;
   logic [NUM_SM*24-1:0]  div_r;
   logic [NUM_SM*32-1:0]  grps_r;
`ifdef PIO_LOADER_SIDES_EN
   logic [NUM_SM*32-1:0]  sides_r;
   logic [31:0]           cur_sides_s;
`endif

   logic                  plen_ok_s, accept_s, last_instr_s;
   logic                  first_found_s, next_found_s;
   logic [1:0]            first_m_s, next_m_s;
   logic [4:0]            cur_pend_s;
   logic [23:0]           cur_div_s;
   logic [31:0]           cur_grps_s;

   logic [3:0]            act_s, action_r;
   logic [4:0]            index_s, index_r;
   logic [1:0]            mindex_s, mindex_r;
   logic [31:0]           din_s, din_r;
   logic                  busy_s, busy_r, done_s, done_r, err_s, err_r;

   assign plen_ok_s    = (plen != 6'd0) && (plen <= 6'd32);
   assign accept_s     = start && plen_ok_s;
   assign last_instr_s = ({1'b0, idx_r} == (plen_r - 6'd1));

   assign action = action_r;
   assign index  = index_r;
   assign mindex = mindex_r;
   assign din    = din_r;
   assign busy   = busy_r;
   assign done   = done_r;
   assign err    = err_r;

   // Program RAM: no reset, writes dropped while a sequence runs.
   always_ff @(posedge clk) begin
      if (prog_we && !busy_r) begin
         prog_mem_r[prog_addr] <= prog_data;
      end
   end

   // Configuration snapshot taken when a start is accepted.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         plen_r  <= 6'd0;
         mask_r  <= '0;
         pend_r  <= '0;
         div_r   <= '0;
         grps_r  <= '0;
`ifdef PIO_LOADER_SIDES_EN
         sides_r <= '0;
`endif
      end else if ((state_r == IDLE) && accept_s) begin
         plen_r  <= plen;
         mask_r  <= sm_en_mask;
         pend_r  <= sm_pend;
         div_r   <= sm_div;
         grps_r  <= sm_grps;
`ifdef PIO_LOADER_SIDES_EN
         sides_r <= sm_sides;
`endif
      end
   end

   // Lowest enabled machine overall, and lowest enabled machine above the current one.
   always_comb begin
      first_found_s = 1'b0;
      first_m_s     = 2'd0;
      next_found_s  = 1'b0;
      next_m_s      = 2'd0;
      for (int m = NUM_SM - 1; m >= 0; m--) begin
         if (mask_r[m]) begin
            first_found_s = 1'b1;
            first_m_s     = 2'(m);
            if (m > int'(m_r)) begin
               next_found_s = 1'b1;
               next_m_s     = 2'(m);
            end else begin
               next_found_s = next_found_s;
               next_m_s     = next_m_s;
            end
         end else begin
            first_found_s = first_found_s;
            first_m_s     = first_m_s;
         end
      end
   end

   // Config fields of the machine currently being emitted.
   always_comb begin
      cur_pend_s  = 5'd0;
      cur_div_s   = 24'd0;
      cur_grps_s  = 32'd0;
`ifdef PIO_LOADER_SIDES_EN
      cur_sides_s = 32'd0;
`endif
      for (int m = 0; m < NUM_SM; m++) begin
         if (m_r == 2'(m)) begin
            cur_pend_s  = pend_r[m*5 +: 5];
            cur_div_s   = div_r[m*24 +: 24];
            cur_grps_s  = grps_r[m*32 +: 32];
`ifdef PIO_LOADER_SIDES_EN
            cur_sides_s = sides_r[m*32 +: 32];
`endif
         end else begin
            cur_pend_s  = cur_pend_s;
         end
      end
   end

   // FSM state and sequence counters.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r <= IDLE;
         idx_r   <= 5'd0;
         m_r     <= 2'd0;
         sub_r   <= 2'd0;
      end else begin
         state_r <= state_nxt_s;
         idx_r   <= idx_nxt_s;
         m_r     <= m_nxt_s;
         sub_r   <= sub_nxt_s;
      end
   end

   // Next-state logic; hold freezes every non-idle state.
   always_comb begin
      state_nxt_s = state_r;
      idx_nxt_s   = idx_r;
      m_nxt_s     = m_r;
      sub_nxt_s   = sub_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               state_nxt_s = INSTR;
               idx_nxt_s   = 5'd0;
               m_nxt_s     = 2'd0;
               sub_nxt_s   = 2'd0;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         INSTR: begin
            if (hold) begin
               state_nxt_s = INSTR;
            end else if (!last_instr_s) begin
               idx_nxt_s = idx_r + 5'd1;
            end else if (first_found_s) begin
               state_nxt_s = CFG;
               m_nxt_s     = first_m_s;
               sub_nxt_s   = 2'd0;
            end else begin
               state_nxt_s = FIN;
            end
         end
         CFG: begin
            if (hold) begin
               state_nxt_s = CFG;
            end else if (sub_r != LAST_SUB) begin
               sub_nxt_s = sub_r + 2'd1;
            end else if (next_found_s) begin
               m_nxt_s   = next_m_s;
               sub_nxt_s = 2'd0;
            end else begin
               state_nxt_s = EN;
               m_nxt_s     = first_m_s;
               sub_nxt_s   = 2'd0;
            end
         end
         EN: begin
            if (hold) begin
               state_nxt_s = EN;
            end else if (next_found_s) begin
               m_nxt_s = next_m_s;
            end else begin
               state_nxt_s = FIN;
            end
         end
         FIN: begin
            if (hold) begin
               state_nxt_s = FIN;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // Action decode for the current step; hold or idle yields an all-zero NONE.
   always_comb begin
      act_s    = ACT_NONE;
      index_s  = 5'd0;
      mindex_s = 2'd0;
      din_s    = 32'd0;
      if (!hold) begin
         case (state_r)
            INSTR: begin
               act_s   = ACT_INSTR;
               index_s = idx_r;
               din_s   = {16'h0000, prog_mem_r[idx_r]};
            end
            CFG: begin
               mindex_s = m_r;
               case (sub_r)
                  2'd0: begin
                     act_s = ACT_PEND;
                     din_s = {27'd0, cur_pend_s};
                  end
                  2'd1: begin
                     act_s = ACT_DIV;
                     din_s = {8'd0, cur_div_s};
                  end
                  2'd2: begin
                     act_s = ACT_GRPS;
                     din_s = cur_grps_s;
                  end
`ifdef PIO_LOADER_SIDES_EN
                  2'd3: begin
                     act_s = ACT_SIDES;
                     din_s = cur_sides_s;
                  end
`endif
                  default: begin
                     act_s = ACT_NONE;
                  end
               endcase
            end
            EN: begin
               act_s    = ACT_EN;
               mindex_s = m_r;
               din_s    = 32'd1;
            end
            default: begin
               act_s = ACT_NONE;
            end
         endcase
      end else begin
         act_s = ACT_NONE;
      end
      done_s = (state_r == FIN) && !hold;
      err_s  = (state_r == IDLE) && start && !plen_ok_s;
      busy_s = (state_nxt_s != IDLE);
   end

   // Registered outputs.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         action_r <= ACT_NONE;
         index_r  <= 5'd0;
         mindex_r <= 2'd0;
         din_r    <= 32'd0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         err_r    <= 1'b0;
      end else begin
         action_r <= act_s;
         index_r  <= index_s;
         mindex_r <= mindex_s;
         din_r    <= din_s;
         busy_r   <= busy_s;
         done_r   <= done_s;
         err_r    <= err_s;
      end
   end

endmodule

// File: tb/tb_pio_loader.sv
// Self-checking bench for pio_loader: queue-based action model plus directed literal scenarios.
module tb_pio_loader;
   localparam int NSM = 4;

   logic           clk = 1'b0;
   logic           resetn = 1'b0;
   logic           prog_we = 1'b0;
   logic [4:0]     prog_addr = 5'd0;
   logic [15:0]    prog_data = 16'd0;
   logic [5:0]     plen = 6'd0;
   logic [NSM-1:0] sm_en_mask = '0;
   logic [NSM*5-1:0]  sm_pend = '0;
   logic [NSM*24-1:0] sm_div = '0;
   logic [NSM*32-1:0] sm_grps = '0;
`ifdef PIO_LOADER_SIDES_EN
   logic [NSM*32-1:0] sm_sides = '0;
`endif
   logic           start = 1'b0;
   logic           hold = 1'b0;
   logic [3:0]     action;
   logic [4:0]     index;
   logic [1:0]     mindex;
   logic [31:0]    din;
   logic           busy, done, err;

   int checks = 0;
   int errors = 0;

   pio_loader #(.NUM_SM(NSM), .PROG_DEPTH(32)) dut (
      .clk(clk), .resetn(resetn), .prog_we(prog_we), .prog_addr(prog_addr),
      .prog_data(prog_data), .plen(plen), .sm_en_mask(sm_en_mask), .sm_pend(sm_pend),
      .sm_div(sm_div), .sm_grps(sm_grps),
`ifdef PIO_LOADER_SIDES_EN
      .sm_sides(sm_sides),
`endif
      .start(start), .hold(hold), .action(action), .index(index), .mindex(mindex),
      .din(din), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0]  act;
      logic [4:0]  idx;
      logic [1:0]  mi;
      logic [31:0] d;
      logic        fin;
   } ent_t;

   ent_t        q[$];
   logic [15:0] mmem [32];
   logic [3:0]  e_act;
   logic [4:0]  e_idx;
   logic [1:0]  e_mi;
   logic [31:0] e_din;
   logic        e_busy, e_done, e_err;

   function automatic ent_t mk(input logic [3:0] a, input logic [4:0] i, input logic [1:0] m,
                               input logic [31:0] d, input logic f);
      ent_t e;
      e.act = a; e.idx = i; e.mi = m; e.d = d; e.fin = f;
      return e;
   endfunction

   // Whole expected action list for a freshly accepted start.
   function automatic void build();
      q.delete();
      for (int i = 0; i < int'(plen); i++) q.push_back(mk(4'd1, 5'(i), 2'd0, {16'h0000, mmem[i]}, 1'b0));
      for (int m = 0; m < NSM; m++) begin
         if (sm_en_mask[m]) begin
            q.push_back(mk(4'd2, 5'd0, 2'(m), {27'd0, sm_pend[m*5 +: 5]}, 1'b0));
            q.push_back(mk(4'd7, 5'd0, 2'(m), {8'd0, sm_div[m*24 +: 24]}, 1'b0));
            q.push_back(mk(4'd5, 5'd0, 2'(m), sm_grps[m*32 +: 32], 1'b0));
`ifdef PIO_LOADER_SIDES_EN
            q.push_back(mk(4'd8, 5'd0, 2'(m), sm_sides[m*32 +: 32], 1'b0));
`endif
         end
      end
      for (int m = 0; m < NSM; m++) begin
         if (sm_en_mask[m]) q.push_back(mk(4'd6, 5'd0, 2'(m), 32'd1, 1'b0));
      end
      q.push_back(mk(4'd0, 5'd0, 2'd0, 32'd0, 1'b1));
   endfunction

   // Model step at each rising edge, compare 1ns later.
   always @(posedge clk) begin
      ent_t e;
      e_act = 4'd0; e_idx = 5'd0; e_mi = 2'd0; e_din = 32'd0;
      e_busy = 1'b0; e_done = 1'b0; e_err = 1'b0;
      if (!resetn) begin
         q.delete();
      end else if (q.size() != 0) begin
         e_busy = 1'b1;
         if (!hold) begin
            e = q.pop_front();
            e_act = e.act; e_idx = e.idx; e_mi = e.mi; e_din = e.d;
            e_done = e.fin; e_busy = !e.fin;
         end
      end else begin
         if (prog_we) mmem[prog_addr] = prog_data;
         if (start) begin
            if (plen >= 6'd1 && plen <= 6'd32) begin
               build();
               e_busy = 1'b1;
            end else begin
               e_err = 1'b1;
            end
         end
      end
      #1;
      checks++;
      if ({action, index, mindex, din, busy, done, err} !== {e_act, e_idx, e_mi, e_din, e_busy, e_done, e_err}) begin
         errors++;
         $display("FAIL model t=%0t got act=%0d idx=%0d m=%0d din=%h busy=%b done=%b err=%b want act=%0d idx=%0d m=%0d din=%h busy=%b done=%b err=%b",
                  $time, action, index, mindex, din, busy, done, err, e_act, e_idx, e_mi, e_din, e_busy, e_done, e_err);
      end
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %h want %h", nm, got, want);
      end
   endtask

   task automatic lit(input string nm, input logic [3:0] a, input logic [4:0] ix, input logic [1:0] mi,
                      input logic [31:0] d, input logic dn);
      @(negedge clk);
      checks++;
      if (action !== a || index !== ix || mindex !== mi || din !== d || done !== dn) begin
         errors++;
         $display("FAIL %s got act=%0d idx=%0d m=%0d din=%h done=%b want act=%0d idx=%0d m=%0d din=%h done=%b",
                  nm, action, index, mindex, din, done, a, ix, mi, d, dn);
      end
   endtask

   task automatic wr(input logic [4:0] a, input logic [15:0] d);
      prog_we = 1'b1; prog_addr = a; prog_data = d;
      @(negedge clk);
      prog_we = 1'b0;
   endtask

   task automatic square_cfg();
      plen = 6'd2; sm_en_mask = 4'b0001;
      sm_pend = '0; sm_pend[4:0] = 5'd1;
      sm_div = '0;  sm_div[23:0] = 24'h000280;
      sm_grps = '0; sm_grps[31:0] = 32'h1;
   endtask

   task automatic run_lat(input int hs, input int hl, output int lat);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = -1;
      for (int n = 1; n <= 100; n++) begin
         hold = (n >= hs) && (n < hs + hl);
         @(negedge clk);
         if (done === 1'b1) begin
            lat = n;
            break;
         end
      end
      hold = 1'b0;
   endtask

   task automatic drain();
      int k = 0;
      while (busy === 1'b1 && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk("drain_busy", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      int lat;
      repeat (3) @(negedge clk);
      chk("reset_action", {28'd0, action}, 32'd0);
      chk("reset_busy", {31'd0, busy}, 32'd0);
      resetn = 1'b1;
      for (int a = 0; a < 32; a++) wr(5'(a), 16'($urandom));
      wr(5'd0, 16'hE001);
      wr(5'd1, 16'hE000);

      // square wave
      square_cfg();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("sq_busy", {31'd0, busy}, 32'd1);
      lit("sq_i0",   4'd1, 5'd0, 2'd0, 32'h0000E001, 1'b0);
      lit("sq_i1",   4'd1, 5'd1, 2'd0, 32'h0000E000, 1'b0);
      lit("sq_pend", 4'd2, 5'd0, 2'd0, 32'h1, 1'b0);
      lit("sq_div",  4'd7, 5'd0, 2'd0, 32'h280, 1'b0);
      lit("sq_grps", 4'd5, 5'd0, 2'd0, 32'h1, 1'b0);
`ifdef PIO_LOADER_SIDES_EN
      lit("sq_sides", 4'd8, 5'd0, 2'd0, 32'h0, 1'b0);
`endif
      lit("sq_en",   4'd6, 5'd0, 2'd0, 32'h1, 1'b0);
      lit("sq_fin",  4'd0, 5'd0, 2'd0, 32'h0, 1'b1);
      chk("sq_busy_end", {31'd0, busy}, 32'd0);
      @(negedge clk);

      // hold three cycles over DIV
      square_cfg();
      run_lat(4, 3, lat);
`ifdef PIO_LOADER_SIDES_EN
      chk("hold_lat", 32'(lat), 32'd11);
`else
      chk("hold_lat", 32'(lat), 32'd10);
`endif
      @(negedge clk);

      // machines 1 and 3
      plen = 6'd1; sm_en_mask = 4'b1010;
      sm_pend = 20'($urandom); sm_div = {$urandom, $urandom, $urandom};
      sm_grps = {$urandom, $urandom, $urandom, $urandom};
      run_lat(0, 0, lat);
`ifdef PIO_LOADER_SIDES_EN
      chk("multi_lat", 32'(lat), 32'd12);
`else
      chk("multi_lat", 32'(lat), 32'd10);
`endif
      @(negedge clk);

      // bad plen values
      plen = 6'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("err_pulse", {31'd0, err}, 32'd1);
      chk("err_busy", {31'd0, busy}, 32'd0);
      chk("err_action", {28'd0, action}, 32'd0);
      @(negedge clk);
      chk("err_clear", {31'd0, err}, 32'd0);
      plen = 6'd33; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("err_33", {31'd0, err}, 32'd1);
      @(negedge clk);

      // reset mid-INSTR then replay from index 0
      plen = 6'd5; sm_en_mask = 4'b0001; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      resetn = 1'b0;
      #1;
      chk("rst_action", {28'd0, action}, 32'd0);
      chk("rst_index", {27'd0, index}, 32'd0);
      chk("rst_din", din, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      resetn = 1'b1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lit("rst_replay", 4'd1, 5'd0, 2'd0, 32'h0000E001, 1'b0);
      drain();
      @(negedge clk);

      // write while busy is dropped
      plen = 6'd3; sm_en_mask = 4'b0000; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wr(5'd0, 16'h1234);
      drain();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lit("bw_orig", 4'd1, 5'd0, 2'd0, 32'h0000E001, 1'b0);
      drain();

      // randomized traffic against the model
      for (int c = 0; c < 4000; c++) begin
         hold = ($urandom_range(0, 9) == 0);
         start = ($urandom_range(0, 7) == 0);
         plen = ($urandom_range(0, 15) == 0) ? 6'($urandom_range(33, 63)) : 6'($urandom_range(0, 32));
         sm_en_mask = 4'($urandom);
         sm_pend = 20'($urandom);
         sm_div = {$urandom, $urandom, $urandom};
         sm_grps = {$urandom, $urandom, $urandom, $urandom};
`ifdef PIO_LOADER_SIDES_EN
         sm_sides = {$urandom, $urandom, $urandom, $urandom};
`endif
         prog_we = ($urandom_range(0, 3) == 0);
         prog_addr = 5'($urandom);
         prog_data = 16'($urandom);
         if ($urandom_range(0, 299) == 0) begin
            resetn = 1'b0;
            prog_we = 1'b0;
         end else begin
            resetn = 1'b1;
         end
         @(negedge clk);
      end
      hold = 1'b0; start = 1'b0; prog_we = 1'b0; resetn = 1'b1;
      drain();
      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end
endmodule
